// File: rtl/top_pkg.sv
// Shared definitions for the AES-128 stego core: FSM states, S-box,
// round constants and GF(2^8) helpers used by the round datapath.
package top_pkg;

    // Phases of one load / encrypt / embed transaction
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ENC   = 2'd1,
        ST_EMBED = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_e;

    localparam logic [3:0] LAST_ROUND = 4'd10;
    localparam logic [6:0] LAST_INDEX = 7'd127;
    localparam logic [2:0] LAST_BIT   = 3'd7;

    // AES forward S-box, entry 0x00 in the top byte, entry 0xff in the bottom byte
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte b lives at bits [8*(255-b)+7 -: 8], i.e. MSB index {~b, 3'b111}
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] msb;
        msb = {~b, 3'b111};
        return SBOX_TABLE[msb -: 8];
    endfunction

    // Round constant for key expansion rounds 1..10, zero otherwise
    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // MixColumns on one column, row 0 in the top byte
    function automatic logic [31:0] mixColumn(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/top_aes128_round.sv
// One combinational AES-128 round plus on-the-fly expansion of the next round key.
// State byte i sits at bits [127-8*i -: 8]; column c is bytes 4c..4c+3.
module aes128_round
    import top_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_roundKey,
    input  logic [7:0]   i_rcon,
    input  logic         i_final,
    output logic [127:0] o_state,
    output logic [127:0] o_nextKey
);

    logic [127:0] w_sub;
    logic [127:0] w_shift;
    logic [127:0] w_mix;
    logic [31:0]  w_rotSub;
    logic [31:0]  w_k0;
    logic [31:0]  w_k1;
    logic [31:0]  w_k2;
    logic [31:0]  w_k3;

    // RotWord + SubWord of the last key word, with Rcon folded into the first byte
    assign w_rotSub = {sbox(i_roundKey[23:16]) ^ i_rcon,
                       sbox(i_roundKey[15:8]),
                       sbox(i_roundKey[7:0]),
                       sbox(i_roundKey[31:24])};

    assign w_k0      = i_roundKey[127:96] ^ w_rotSub;
    assign w_k1      = i_roundKey[95:64]  ^ w_k0;
    assign w_k2      = i_roundKey[63:32]  ^ w_k1;
    assign w_k3      = i_roundKey[31:0]   ^ w_k2;
    assign o_nextKey = {w_k0, w_k1, w_k2, w_k3};

    // SubBytes, ShiftRows (row r rotated left by r) and MixColumns
    always_comb begin
        w_sub   = '0;
        w_shift = '0;
        w_mix   = '0;
        for (int i = 0; i < 16; i++) begin
            w_sub[127-8*i -: 8] = sbox(i_state[127-8*i -: 8]);
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                w_shift[127-8*(r+4*c) -: 8] = w_sub[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mix[127-32*c -: 32] = mixColumn(w_shift[127-32*c -: 32]);
        end
    end

    // The last round has no MixColumns
    assign o_state = (i_final ? w_shift : w_mix) ^ o_nextKey;

endmodule

// File: rtl/top.sv
// Serial AES-128 (single-block CBC) encryptor followed by LSB steganographic
// embedding of the 128 ciphertext bits into 128 serially delivered cover bytes.
module top
    import top_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    input  logic       payload,
    input  logic       IV,
    input  logic       cover_in,   // cover-data serial bit ("cover" is a reserved word)
    output logic [7:0] out,
    output logic       flag1,
    output logic       flag2,
    output logic [6:0] count,
    output logic       flag_sinp
);

    fsm_state_e   r_state;
    fsm_state_e   w_nextState;

    logic [127:0] r_key;
    logic [127:0] r_payload;
    logic [127:0] r_iv;
    logic [127:0] r_aes;
    logic [127:0] r_roundKey;
    logic [127:0] r_ct;
    logic [3:0]   r_round;
    logic [6:0]   r_coverSr;
    logic [2:0]   r_bitCnt;
    logic [7:0]   r_out;
    logic [6:0]   r_count;
    logic         r_flagSinp;
    logic         r_flag1;
    logic         r_flag2;

    logic         w_loadDone;
    logic         w_encLast;
    logic         w_byteDone;
    logic         w_embedDone;
    logic         w_ctBit;
    logic [127:0] w_roundOut;
    logic [127:0] w_nextKey;

    aes128_round u_round (
        .i_state    (r_aes),
        .i_roundKey (r_roundKey),
        .i_rcon     (rcon(r_round)),
        .i_final    (r_round == LAST_ROUND),
        .o_state    (w_roundOut),
        .o_nextKey  (w_nextKey)
    );

    // Ciphertext bit for the byte currently being assembled, MSB first
    assign w_ctBit = r_ct[LAST_INDEX - r_count];

    // Phase register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_LOAD;
        else     r_state <= w_nextState;
    end

    // Phase transitions and the per-cycle completion strobes that drive them
    always_comb begin
        w_nextState = r_state;
        w_loadDone  = 1'b0;
        w_encLast   = 1'b0;
        w_byteDone  = 1'b0;
        w_embedDone = 1'b0;
        case (r_state)
            ST_LOAD: begin
                if (r_count == LAST_INDEX) begin
                    w_loadDone  = 1'b1;
                    w_nextState = ST_ENC;
                end
            end
            ST_ENC: begin
                if (r_round == LAST_ROUND) begin
                    w_encLast   = 1'b1;
                    w_nextState = ST_EMBED;
                end
            end
            ST_EMBED: begin
                if (r_bitCnt == LAST_BIT) begin
                    w_byteDone = 1'b1;
                    if (r_count == LAST_INDEX) begin
                        w_embedDone = 1'b1;
                        w_nextState = ST_DONE;
                    end
                end
            end
            ST_DONE: w_nextState = ST_DONE;
            default: w_nextState = ST_LOAD;
        endcase
    end

    // Serial key/payload/IV capture; the first bit received ends up as the MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key     <= '0;
            r_payload <= '0;
            r_iv      <= '0;
        end else if (r_state == ST_LOAD) begin
            r_key     <= {r_key[126:0], key};
            r_payload <= {r_payload[126:0], payload};
            r_iv      <= {r_iv[126:0], IV};
        end
    end

    // Encryption: one whitening cycle, then one round per cycle for ten rounds
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aes      <= '0;
            r_roundKey <= '0;
            r_round    <= '0;
            r_ct       <= '0;
        end else if (r_state == ST_ENC) begin
            if (r_round == 4'd0) begin
                r_aes      <= (r_payload ^ r_iv) ^ r_key;
                r_roundKey <= r_key;
                r_round    <= 4'd1;
            end else begin
                r_aes      <= w_roundOut;
                r_roundKey <= w_nextKey;
                if (w_encLast) begin
                    r_ct    <= w_roundOut;
                    r_round <= 4'd0;
                end else begin
                    r_round <= r_round + 4'd1;
                end
            end
        end
    end

    // Cover capture and stego byte: the top 7 cover bits plus one ciphertext bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_coverSr <= '0;
            r_bitCnt  <= '0;
            r_out     <= '0;
        end else if (r_state == ST_EMBED) begin
            r_coverSr <= {r_coverSr[5:0], cover_in};
            r_bitCnt  <= r_bitCnt + 3'd1;
            if (w_byteDone) begin
                r_out <= {r_coverSr, w_ctBit};
            end
        end
    end

    // Bit/byte index and the sticky phase-complete flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_flagSinp <= 1'b0;
            r_flag1    <= 1'b0;
            r_flag2    <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_count <= r_count + 7'd1;
                    if (w_loadDone) r_flagSinp <= 1'b1;
                end
                ST_ENC: begin
                    if (w_encLast) r_flag1 <= 1'b1;
                end
                ST_EMBED: begin
                    if (w_embedDone)     r_flag2 <= 1'b1;
                    else if (w_byteDone) r_count <= r_count + 7'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign out       = r_out;
    assign count     = r_count;
    assign flag1     = r_flag1;
    assign flag2     = r_flag2;
    assign flag_sinp = r_flagSinp;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the serial AES-128 stego core, using a byte-level
// AES reference whose S-box is derived from GF(2^8) inversion.
module tb_top;

    logic       clk = 1'b0;
    logic       rst;
    logic       key;
    logic       payload;
    logic       IV;
    logic       cover_in;
    logic [7:0] out;
    logic       flag1;
    logic       flag2;
    logic [6:0] count;
    logic       flag_sinp;

    int passCount  = 0;
    int checkCount = 0;

    logic [7:0] sbRef [256];

    top dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .payload   (payload),
        .IV        (IV),
        .cover_in  (cover_in),
        .out       (out),
        .flag1     (flag1),
        .flag2     (flag2),
        .count     (count),
        .flag_sinp (flag_sinp)
    );

    always #5 clk = ~clk;

    // GF(2^8) multiply, shift-and-add
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse then affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbRef[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Plain AES-128 encryption on a 16-byte array (byte i = row i%4, column i/4)
    function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] pt);
        logic [7:0]   s   [16];
        logic [7:0]   t   [16];
        logic [7:0]   rk  [16];
        logic [7:0]   tmp [4];
        logic [7:0]   rc;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            rk[i] = k[127-8*i -: 8];
            s[i]  = pt[127-8*i -: 8] ^ rk[i];
        end
        for (int rnd = 1; rnd <= 10; rnd++) begin
            tmp[0] = sbRef[rk[13]] ^ rc;
            tmp[1] = sbRef[rk[14]];
            tmp[2] = sbRef[rk[15]];
            tmp[3] = sbRef[rk[12]];
            for (int j = 0; j < 4; j++)  rk[j] = rk[j] ^ tmp[j];
            for (int j = 4; j < 16; j++) rk[j] = rk[j] ^ rk[j-4];
            rc = gmul(rc, 8'h02);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r+4*c] = sbRef[s[r+4*((c+r)%4)]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r+4*c] = (rnd == 10) ? t[r+4*c]
                             : gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03)
                               ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[i];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_vec(output logic [127:0] v);
        v = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // One reset cycle with junk on every input; all outputs must read zero afterwards
    task automatic test_reset(input string where);
        rst      = 1'b1;
        key      = 1'($urandom);
        payload  = 1'($urandom);
        IV       = 1'($urandom);
        cover_in = 1'($urandom);
        tick();
        checkCount++;
        if ({out, count, flag1, flag2, flag_sinp} !== 19'd0)
            $display("[TB] FAIL reset_%s: out=%h count=%0d f1=%b f2=%b fs=%b, required all zero",
                     where, out, count, flag1, flag2, flag_sinp);
        else passCount++;
        rst = 1'b0;
    endtask

    // Shift nbits of key/payload/IV MSB first, with cover toggling as noise
    task automatic load_block(input logic [127:0] k, input logic [127:0] p,
                              input logic [127:0] v, input int nbits);
        for (int n = 1; n <= nbits; n++) begin
            key      = k[128-n];
            payload  = p[128-n];
            IV       = v[128-n];
            cover_in = 1'($urandom);
            tick();
            checkCount++;
            if (count !== 7'(n % 128) || flag_sinp !== (n == 128))
                $display("[TB] FAIL load_bit%0d: count=%0d fs=%b, required count=%0d fs=%b",
                         n, count, flag_sinp, n % 128, (n == 128));
            else passCount++;
        end
    endtask

    // ncyc encryption cycles; flag1 must rise on exactly the 11th
    task automatic run_enc(input logic [127:0] expCt, input int ncyc);
        for (int c = 1; c <= ncyc; c++) begin
            key      = 1'($urandom);
            payload  = 1'($urandom);
            IV       = 1'($urandom);
            cover_in = 1'($urandom);
            tick();
            checkCount++;
            if (flag1 !== (c == 11) || count !== 7'd0)
                $display("[TB] FAIL enc_cycle%0d: flag1=%b count=%0d, required flag1=%b count=0",
                         c, flag1, count, (c == 11));
            else passCount++;
        end
        if (ncyc == 11) begin
            checkCount++;
            if (dut.r_ct !== expCt)
                $display("[TB] FAIL ciphertext: got %h required %h", dut.r_ct, expCt);
            else passCount++;
        end
    endtask

    // Feed nbytes cover bytes (all 0xFF or random) while key/payload/IV toggle as noise
    task automatic run_embed(input logic [127:0] expCt, input bit allOnes,
                             input int nbytes, output logic [7:0] lastOut);
        logic [7:0]   cb;
        logic [7:0]   expOut;
        logic [127:0] rebuilt;
        expOut  = 8'h00;
        rebuilt = '0;
        for (int b = 0; b < nbytes; b++) begin
            cb = allOnes ? 8'hff : 8'($urandom);
            for (int bit_i = 7; bit_i >= 0; bit_i--) begin
                cover_in = cb[bit_i];
                key      = 1'($urandom);
                payload  = 1'($urandom);
                IV       = 1'($urandom);
                tick();
                if (bit_i != 0) begin
                    checkCount++;
                    if (out !== expOut || count !== 7'(b) || flag2 !== 1'b0)
                        $display("[TB] FAIL embed_hold_b%0d: out=%h count=%0d f2=%b, required out=%h count=%0d f2=0",
                                 b, out, count, flag2, expOut, b);
                    else passCount++;
                end
            end
            expOut = {cb[7:1], expCt[127-b]};
            rebuilt[127-b] = out[0];
            checkCount++;
            if (out !== expOut || count !== 7'((b == 127) ? 127 : b + 1) || flag2 !== (b == 127))
                $display("[TB] FAIL embed_byte%0d: out=%h count=%0d f2=%b, required out=%h count=%0d f2=%b",
                         b, out, count, flag2, expOut, (b == 127) ? 127 : b + 1, (b == 127));
            else passCount++;
        end
        if (nbytes == 128) begin
            checkCount++;
            if (rebuilt !== expCt)
                $display("[TB] FAIL embedded_ct: recovered %h required %h", rebuilt, expCt);
            else passCount++;
        end
        lastOut = expOut;
    endtask

    // DONE must ignore every input and freeze out, count and flags
    task automatic test_done(input logic [7:0] expOut);
        for (int c = 1; c <= 100; c++) begin
            key      = 1'($urandom);
            payload  = 1'($urandom);
            IV       = 1'($urandom);
            cover_in = 1'($urandom);
            tick();
            checkCount++;
            if ({out, count, flag1, flag2, flag_sinp} !== {expOut, 7'd127, 3'b111})
                $display("[TB] FAIL done_cycle%0d: out=%h count=%0d flags=%b%b%b, required out=%h count=127 flags=111",
                         c, out, count, flag1, flag2, flag_sinp, expOut);
            else passCount++;
        end
    endtask

    task automatic full_run(input logic [127:0] k, input logic [127:0] p,
                            input logic [127:0] v, input bit allOnes);
        logic [127:0] ct;
        logic [7:0]   lastOut;
        ct = aes_model(k, p ^ v);
        load_block(k, p, v, 128);
        run_enc(ct, 11);
        run_embed(ct, allOnes, 128, lastOut);
        test_done(lastOut);
    endtask

    task automatic test_fips();
        logic [127:0] k;
        logic [127:0] p;
        k = 128'h000102030405060708090a0b0c0d0e0f;
        p = 128'h00112233445566778899aabbccddeeff;
        test_reset("pre_fips");
        full_run(k, p, 128'h0, 1'b1);
        checkCount++;
        if (dut.r_ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a)
            $display("[TB] FAIL fips_known_answer: got %h required 69c4e0d86a7b0430d8cdb78070b4c55a", dut.r_ct);
        else passCount++;
    endtask

    task automatic test_iv_eq_payload();
        logic [127:0] k;
        logic [127:0] p;
        logic [7:0]   lastOut;
        k = 128'h000102030405060708090a0b0c0d0e0f;
        p = 128'h00112233445566778899aabbccddeeff;
        test_reset("pre_cbc");
        load_block(k, p, p, 128);
        run_enc(aes_model(k, 128'h0), 11);
        checkCount++;
        if (dut.r_ct !== 128'hc6a13b37878f5b826f4f8162a1c8d879)
            $display("[TB] FAIL cbc_zero_block: got %h required c6a13b37878f5b826f4f8162a1c8d879", dut.r_ct);
        else passCount++;
        run_embed(aes_model(k, 128'h0), 1'b0, 128, lastOut);
    endtask

    task automatic test_reset_midload();
        logic [127:0] k, p, v;
        rand_vec(k); rand_vec(p); rand_vec(v);
        test_reset("pre_midload");
        load_block(k, p, v, 64);
        test_reset("mid_load");
        rand_vec(k); rand_vec(p); rand_vec(v);
        full_run(k, p, v, 1'b0);
    endtask

    task automatic test_reset_midop();
        logic [127:0] k, p, v;
        logic [7:0]   lastOut;
        rand_vec(k); rand_vec(p); rand_vec(v);
        test_reset("pre_midenc");
        load_block(k, p, v, 128);
        run_enc(aes_model(k, p ^ v), 5);
        test_reset("mid_enc");
        load_block(k, p, v, 128);
        run_enc(aes_model(k, p ^ v), 11);
        run_embed(aes_model(k, p ^ v), 1'b0, 37, lastOut);
        test_reset("mid_embed");
        rand_vec(k); rand_vec(p); rand_vec(v);
        full_run(k, p, v, 1'b0);
        test_reset("in_done");
    endtask

    task automatic test_random(input int runs);
        logic [127:0] k, p, v;
        for (int r = 0; r < runs; r++) begin
            rand_vec(k); rand_vec(p); rand_vec(v);
            test_reset("pre_random");
            full_run(k, p, v, 1'b0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        key      = 1'b0;
        payload  = 1'b0;
        IV       = 1'b0;
        cover_in = 1'b0;
        build_sbox();
        tick();
        test_reset("power_on");
        test_fips();
        test_iv_eq_payload();
        test_reset_midload();
        test_reset_midop();
        test_random(2);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
